// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm bank and its channels.
package alarm_pkg;

    localparam int unsigned DAY_SECS_DEF = 86400;
    localparam int unsigned CNT_W        = 6;
    localparam int unsigned LEN_W        = 2;

    typedef enum logic [1:0] {
        A_IDLE = 2'd0,
        A_RING = 2'd1,
        A_SNZ  = 2'd2
    } alarm_state_e;

    // Ring length in ticks for a length code: 15/30/45/60.
    function automatic logic [CNT_W-1:0] len2secs(input logic [LEN_W-1:0] len);
        logic [CNT_W-1:0] n;
        n = CNT_W'(len) + CNT_W'(1);
        return CNT_W'(n * CNT_W'(15));
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: config registers plus the ring/snooze state machine.
module alarm_channel
    import alarm_pkg::*;
#(
    parameter int unsigned SEC_W       = 17,
    parameter int unsigned MUSIC_W     = 2,
    parameter int unsigned DAY_SECS    = DAY_SECS_DEF,
    parameter int unsigned SNOOZE_SECS = 300,
    parameter int unsigned MAX_SNOOZE  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_1hz,
    input  logic [SEC_W-1:0]   now_sec,
    input  logic               wr_en,
    input  logic [SEC_W-1:0]   wr_sec,
    input  logic [LEN_W-1:0]   wr_len,
    input  logic [MUSIC_W-1:0] wr_music,
    input  logic               wr_on,
    input  logic               dismiss,
    input  logic               snooze,
    output logic [SEC_W-1:0]   cfg_sec,
    output logic [LEN_W-1:0]   cfg_len,
    output logic [MUSIC_W-1:0] cfg_music,
    output logic               cfg_on,
    output logic               ring_c
);

    localparam int unsigned SNZ_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
    localparam int unsigned SUM_W = SEC_W + 1;

    logic [SEC_W-1:0]   sec_q;
    logic [LEN_W-1:0]   len_q;
    logic [MUSIC_W-1:0] music_q;
    logic               on_q;

    alarm_state_e       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEC_W-1:0]   snz_sec_q, snz_sec_d;
    logic [SNZ_W-1:0]   snz_n_q, snz_n_d;

    logic [SUM_W-1:0]   snz_sum;
    logic [SEC_W-1:0]   snz_target;

    // Snooze target time, wrapped at midnight.
    assign snz_sum    = SUM_W'(now_sec) + SUM_W'(SNOOZE_SECS);
    assign snz_target = (snz_sum >= SUM_W'(DAY_SECS)) ? SEC_W'(snz_sum - SUM_W'(DAY_SECS))
                                                      : SEC_W'(snz_sum);

    // Config registers, loaded by the write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sec_q   <= '0;
            len_q   <= '0;
            music_q <= '0;
            on_q    <= 1'b0;
        end else if (wr_en) begin
            sec_q   <= wr_sec;
            len_q   <= wr_len;
            music_q <= wr_music;
            on_q    <= wr_on;
        end
    end

    // FSM state and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= A_IDLE;
            cnt_q     <= '0;
            snz_sec_q <= '0;
            snz_n_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            snz_sec_q <= snz_sec_d;
            snz_n_q   <= snz_n_d;
        end
    end

    // Next state: write beats user action beats tick; dismiss beats snooze.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        snz_sec_d = snz_sec_q;
        snz_n_d   = snz_n_q;
        if (wr_en) begin
            state_d = A_IDLE;
        end else if (dismiss && (state_q == A_RING)) begin
            state_d = A_IDLE;
        end else if (snooze && (state_q == A_RING)) begin
            if (snz_n_q < SNZ_W'(MAX_SNOOZE)) begin
                state_d   = A_SNZ;
                snz_sec_d = snz_target;
                snz_n_d   = snz_n_q + SNZ_W'(1);
            end else begin
                state_d = A_IDLE;
            end
        end else if (tick_1hz) begin
            unique case (state_q)
                A_IDLE: begin
                    if (on_q && (now_sec == sec_q)) begin
                        state_d = A_RING;
                        cnt_d   = len2secs(len_q);
                        snz_n_d = '0;
                    end
                end
                A_RING: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = A_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                A_SNZ: begin
                    if (now_sec == snz_sec_q) begin
                        state_d = A_RING;
                        cnt_d   = len2secs(len_q);
                    end
                end
                default: state_d = A_IDLE;
            endcase
        end
    end

    assign cfg_sec   = sec_q;
    assign cfg_len   = len_q;
    assign cfg_music = music_q;
    assign cfg_on    = on_q;
    assign ring_c    = (state_q == A_RING);

endmodule

// File: rtl/alarm_bank.sv
// Bank of daily alarms: write decode, config readback, ringing-channel arbitration.
module alarm_bank
    import alarm_pkg::*;
#(
    parameter int unsigned N_ALARMS    = 4,
    parameter int unsigned IDX_W       = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1,
    parameter int unsigned SEC_W       = 17,
    parameter int unsigned DAY_SECS    = DAY_SECS_DEF,
    parameter int unsigned SNOOZE_SECS = 300,
    parameter int unsigned MAX_SNOOZE  = 3,
    parameter int unsigned MUSIC_W     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_1hz,
    input  logic [SEC_W-1:0]    now_sec,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [SEC_W-1:0]    wr_sec,
    input  logic [1:0]          wr_len,
    input  logic [MUSIC_W-1:0]  wr_music,
    input  logic                wr_on,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [SEC_W-1:0]    rd_sec,
    output logic [1:0]          rd_len,
    output logic [MUSIC_W-1:0]  rd_music,
    output logic                rd_on,
    input  logic                dismiss,
    input  logic                snooze,
    output logic                ringing,
    output logic [IDX_W-1:0]    ring_idx,
    output logic [MUSIC_W-1:0]  ring_music,
    output logic [N_ALARMS-1:0] on_mask
);

    logic [SEC_W-1:0]    ch_sec   [N_ALARMS];
    logic [LEN_W-1:0]    ch_len   [N_ALARMS];
    logic [MUSIC_W-1:0]  ch_music [N_ALARMS];
    logic [N_ALARMS-1:0] ch_on;
    logic [N_ALARMS-1:0] ch_ring;
    logic [N_ALARMS-1:0] ch_wr;
    logic [N_ALARMS-1:0] ch_dismiss;
    logic [N_ALARMS-1:0] ch_snooze;

    logic                ringing_q, ringing_d;
    logic [IDX_W-1:0]    ring_idx_q, ring_idx_d;
    logic [MUSIC_W-1:0]  ring_music_q, ring_music_d;

    // Per-channel instances; user actions only reach the currently selected channel.
    for (genvar g = 0; g < N_ALARMS; g++) begin : g_ch
        assign ch_wr[g]      = wr_en && (wr_idx == IDX_W'(g));
        assign ch_dismiss[g] = dismiss && ringing_q && (ring_idx_q == IDX_W'(g));
        assign ch_snooze[g]  = snooze && ringing_q && (ring_idx_q == IDX_W'(g));

        alarm_channel #(
            .SEC_W       (SEC_W),
            .MUSIC_W     (MUSIC_W),
            .DAY_SECS    (DAY_SECS),
            .SNOOZE_SECS (SNOOZE_SECS),
            .MAX_SNOOZE  (MAX_SNOOZE)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .tick_1hz  (tick_1hz),
            .now_sec   (now_sec),
            .wr_en     (ch_wr[g]),
            .wr_sec    (wr_sec),
            .wr_len    (wr_len),
            .wr_music  (wr_music),
            .wr_on     (wr_on),
            .dismiss   (ch_dismiss[g]),
            .snooze    (ch_snooze[g]),
            .cfg_sec   (ch_sec[g]),
            .cfg_len   (ch_len[g]),
            .cfg_music (ch_music[g]),
            .cfg_on    (ch_on[g]),
            .ring_c    (ch_ring[g])
        );
    end

    // Config readback; out-of-range index reads as zero.
    always_comb begin
        rd_sec   = '0;
        rd_len   = '0;
        rd_music = '0;
        rd_on    = 1'b0;
        for (int i = 0; i < int'(N_ALARMS); i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_sec   = ch_sec[i];
                rd_len   = ch_len[i];
                rd_music = ch_music[i];
                rd_on    = ch_on[i];
            end
        end
    end

    // Lowest-index ringing channel wins.
    always_comb begin
        ringing_d    = 1'b0;
        ring_idx_d   = '0;
        ring_music_d = '0;
        for (int i = int'(N_ALARMS) - 1; i >= 0; i--) begin
            if (ch_ring[i]) begin
                ringing_d    = 1'b1;
                ring_idx_d   = IDX_W'(i);
                ring_music_d = ch_music[i];
            end
        end
    end

    // Registered arbitration result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ringing_q    <= 1'b0;
            ring_idx_q   <= '0;
            ring_music_q <= '0;
        end else begin
            ringing_q    <= ringing_d;
            ring_idx_q   <= ring_idx_d;
            ring_music_q <= ring_music_d;
        end
    end

    assign ringing    = ringing_q;
    assign ring_idx   = ring_idx_q;
    assign ring_music = ring_music_q;
    assign on_mask    = ch_on;

endmodule

// File: tb/tb_alarm_bank.sv
// Scoreboard bench for alarm_bank: stimulus queues expectations, a monitor checks them.
module tb_alarm_bank;

    localparam int unsigned N       = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned SEC_W   = 17;
    localparam int unsigned MUSIC_W = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               tick_1hz = 1'b0;
    logic [SEC_W-1:0]   now_sec = '0;
    logic               wr_en = 1'b0;
    logic [IDX_W-1:0]   wr_idx = '0;
    logic [SEC_W-1:0]   wr_sec = '0;
    logic [1:0]         wr_len = '0;
    logic [MUSIC_W-1:0] wr_music = '0;
    logic               wr_on = 1'b0;
    logic [IDX_W-1:0]   rd_idx = '0;
    logic [SEC_W-1:0]   rd_sec;
    logic [1:0]         rd_len;
    logic [MUSIC_W-1:0] rd_music;
    logic               rd_on;
    logic               dismiss = 1'b0;
    logic               snooze = 1'b0;
    logic               ringing;
    logic [IDX_W-1:0]   ring_idx;
    logic [MUSIC_W-1:0] ring_music;
    logic [N-1:0]       on_mask;

    alarm_bank dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .now_sec    (now_sec),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_sec     (wr_sec),
        .wr_len     (wr_len),
        .wr_music   (wr_music),
        .wr_on      (wr_on),
        .rd_idx     (rd_idx),
        .rd_sec     (rd_sec),
        .rd_len     (rd_len),
        .rd_music   (rd_music),
        .rd_on      (rd_on),
        .dismiss    (dismiss),
        .snooze     (snooze),
        .ringing    (ringing),
        .ring_idx   (ring_idx),
        .ring_music (ring_music),
        .on_mask    (on_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        string              name;
        logic               ring;
        logic [IDX_W-1:0]   idx;
        logic [MUSIC_W-1:0] mus;
        logic [N-1:0]       mask;
        bit                 chk_rd;
        logic [SEC_W-1:0]   rsec;
        logic [1:0]         rlen;
        logic [MUSIC_W-1:0] rmus;
        logic               ron;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    logic [N-1:0] exp_mask = '0;

    // Monitor: compare one queued expectation per falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (ringing !== e.ring || ring_idx !== e.idx || ring_music !== e.mus || on_mask !== e.mask) begin
                errors++;
                $display("FAIL %s: got ringing=%0b idx=%0d music=%0d on_mask=%b, expected %0b %0d %0d %b",
                         e.name, ringing, ring_idx, ring_music, on_mask, e.ring, e.idx, e.mus, e.mask);
            end
            if (e.chk_rd) begin
                checks++;
                if (rd_sec !== e.rsec || rd_len !== e.rlen || rd_music !== e.rmus || rd_on !== e.ron) begin
                    errors++;
                    $display("FAIL %s readback: got sec=%0d len=%0d music=%0d on=%0b, expected %0d %0d %0d %0b",
                             e.name, rd_sec, rd_len, rd_music, rd_on, e.rsec, e.rlen, e.rmus, e.ron);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string name, input logic r, input int idx, input int mus,
                        input bit chk, input int rsec, input int rlen, input int rmus, input logic ron);
        exp_t e;
        e.name   = name;
        e.ring   = r;
        e.idx    = IDX_W'(idx);
        e.mus    = MUSIC_W'(mus);
        e.mask   = exp_mask;
        e.chk_rd = chk;
        e.rsec   = SEC_W'(rsec);
        e.rlen   = 2'(rlen);
        e.rmus   = MUSIC_W'(rmus);
        e.ron    = ron;
        sb.push_back(e);
    endtask

    task automatic expect_st(input string name, input logic r, input int idx, input int mus);
        push(name, r, idx, mus, 1'b0, 0, 0, 0, 1'b0);
        cyc();
    endtask

    task automatic expect_rd(input string name, input logic r, input int idx, input int mus,
                             input int ch, input int rsec, input int rlen, input int rmus, input logic ron);
        rd_idx = IDX_W'(ch);
        push(name, r, idx, mus, 1'b1, rsec, rlen, rmus, ron);
        cyc();
    endtask

    task automatic wr(input int idx, input int sec, input int len, input int mus, input logic on);
        wr_en    = 1'b1;
        wr_idx   = IDX_W'(idx);
        wr_sec   = SEC_W'(sec);
        wr_len   = 2'(len);
        wr_music = MUSIC_W'(mus);
        wr_on    = on;
        cyc();
        wr_en = 1'b0;
        exp_mask[idx] = on;
        cyc();
    endtask

    task automatic tick(input int sec);
        now_sec  = SEC_W'(sec);
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        cyc();
    endtask

    task automatic press(input logic d, input logic s);
        dismiss = d;
        snooze  = s;
        cyc();
        dismiss = 1'b0;
        snooze  = 1'b0;
        cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end, expected finish");
        $fatal(1);
    end

    initial begin
        cyc();
        cyc();
        expect_rd("reset_state", 1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
        rst = 1'b1;
        cyc();

        // Single alarm, ring length 15 ticks
        wr(1, 3600, 0, 2, 1'b1);
        expect_rd("write_ch1", 1'b0, 0, 0, 1, 3600, 0, 2, 1'b1);
        tick(3599);
        expect_st("before_match", 1'b0, 0, 0);
        tick(3600);
        expect_st("match_ch1", 1'b1, 1, 2);
        for (int s = 3601; s <= 3614; s++) tick(s);
        expect_st("ring_tick14", 1'b1, 1, 2);
        tick(3615);
        expect_st("ring_end_tick15", 1'b0, 0, 0);

        // Two simultaneous alarms, priority and dismiss
        wr(0, 700, 1, 1, 1'b1);
        wr(2, 700, 2, 3, 1'b1);
        tick(700);
        expect_st("prio_ch0", 1'b1, 0, 1);
        press(1'b1, 1'b0);
        expect_st("dismiss_to_ch2", 1'b1, 2, 3);
        press(1'b1, 1'b0);
        expect_st("dismiss_all", 1'b0, 0, 0);
        press(1'b1, 1'b1);
        expect_st("dismiss_idle_ignored", 1'b0, 0, 0);

        // Snooze across midnight, fourth snooze dismisses
        wr(3, 86300, 0, 1, 1'b1);
        tick(86300);
        expect_st("match_ch3", 1'b1, 3, 1);
        press(1'b0, 1'b1);
        expect_st("snooze1_idle", 1'b0, 0, 0);
        tick(199);
        expect_st("snooze1_wait", 1'b0, 0, 0);
        tick(200);
        expect_st("snooze1_wrap_ring", 1'b1, 3, 1);
        press(1'b0, 1'b1);
        tick(500);
        expect_st("snooze2_ring", 1'b1, 3, 1);
        press(1'b0, 1'b1);
        expect_st("snooze3_idle", 1'b0, 0, 0);
        tick(800);
        expect_st("snooze3_ring", 1'b1, 3, 1);
        press(1'b0, 1'b1);
        expect_st("snooze4_dismiss", 1'b0, 0, 0);
        tick(1100);
        expect_st("no_ring_after_dismiss", 1'b0, 0, 0);

        // Write on the same clock as a tick to a ringing channel
        tick(86300);
        expect_st("ring_before_write", 1'b1, 3, 1);
        now_sec  = SEC_W'(86301);
        tick_1hz = 1'b1;
        wr_en    = 1'b1;
        wr_idx   = IDX_W'(3);
        wr_sec   = SEC_W'(1000);
        wr_len   = 2'd3;
        wr_music = MUSIC_W'(2);
        wr_on    = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        wr_en    = 1'b0;
        cyc();
        expect_rd("write_over_ring", 1'b0, 0, 0, 3, 1000, 3, 2, 1'b1);

        // Skipped match time and disabled channel
        wr(2, 2000, 0, 0, 1'b1);
        tick(1999);
        tick(2001);
        expect_st("skip_no_ring", 1'b0, 0, 0);
        wr(0, 2500, 0, 1, 1'b0);
        tick(2500);
        expect_st("disabled_no_ring", 1'b0, 0, 0);

        // Asynchronous reset in the middle of a ring
        tick(1000);
        expect_st("ring_before_reset", 1'b1, 3, 2);
        rst      = 1'b0;
        exp_mask = '0;
        push("async_reset", 1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0);
        @(negedge clk);
        #1;
        cyc();
        rst = 1'b1;
        cyc();
        for (int i = 0; i < int'(N); i++) begin
            expect_rd("post_reset_rd", 1'b0, 0, 0, i, 0, 0, 0, 1'b0);
        end

        cyc();
        cyc();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
